// File: rtl/sector_pkg.sv
// Shared definitions for the sector reader: sector geometry and FSM state encoding.
package sector_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int SD_IDX_W     = 9;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      STREAM
   } sector_state_t;

endpackage

// File: rtl/sector_ram.sv
// 512x8 simple dual-port sector buffer; one write port, registered read port, no reset.
module sector_ram
   import sector_pkg::*;
(
   input  logic                clk_i,
   input  logic                wr_en_i,
   input  logic [SD_IDX_W-1:0] wr_addr_i,
   input  logic [7:0]          wr_data_i,
   input  logic [SD_IDX_W-1:0] rd_addr_i,
   output logic [7:0]          rd_data_o
);

   logic [7:0] mem [SECTOR_BYTES];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem[rd_addr_i];
   end

endmodule

// File: rtl/sector_reader.sv
// Requests one sector from the image controller, buffers the 512 delivered bytes
// and streams them out over a valid/ready interface.
module sector_reader
   import sector_pkg::*;
#(
   parameter int TIMEOUT_CYC = 65535,
   parameter int LBA_W       = 32
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             req_i,
   input  logic [LBA_W-1:0] lba_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LBA_W-1:0] sd_lba_o,
   output logic [1:0]       sd_rd_o,
   output logic [1:0]       sd_wr_o,
   input  logic             sd_ack_i,
   input  logic [8:0]       sd_buff_addr_i,
   input  logic [7:0]       sd_buff_dout_i,
   input  logic             sd_buff_wr_i,
   output logic [7:0]       sd_buff_din_o,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   output logic             last_o
);

   sector_state_t       state_q;
   logic [LBA_W-1:0]    lba_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic                rd_q;
   logic                valid_q;
   logic [9:0]          cnt_q;
   logic [9:0]          cnt_d;
   logic [31:0]         tmo_q;
   logic [SD_IDX_W-1:0] rp_q;
   logic [SD_IDX_W-1:0] rd_addr;
   logic                tmo_hit;
   logic                ram_we;
   logic [7:0]          ram_q;

   // The byte count includes a strobe arriving on the same cycle the ack falls.
   assign cnt_d   = cnt_q + 10'(sd_buff_wr_i);
   assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYC - 1));
   assign ram_we  = (state_q == FILL) && sd_buff_wr_i;
   assign rd_addr = (valid_q && byte_ready_i) ? rp_q + 9'd1 : rp_q;

   sector_ram u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (ram_we),
      .wr_addr_i (sd_buff_addr_i),
      .wr_data_i (sd_buff_dout_i),
      .rd_addr_i (rd_addr),
      .rd_data_o (ram_q)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         lba_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         rp_q    <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  lba_q   <= lba_i;
                  cnt_q   <= '0;
                  tmo_q   <= '0;
                  busy_q  <= 1'b1;
                  rd_q    <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (sd_ack_i) begin
                  rd_q    <= 1'b0;
                  cnt_q   <= '0;
                  tmo_q   <= '0;
                  state_q <= FILL;
               end else if (tmo_hit) begin
                  rd_q    <= 1'b0;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            FILL: begin
               cnt_q <= cnt_d;
               if (!sd_ack_i) begin
                  if (cnt_d == 10'(SECTOR_BYTES)) begin
                     rp_q    <= '0;
                     valid_q <= 1'b0;
                     tmo_q   <= '0;
                     state_q <= STREAM;
                  end else begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            STREAM: begin
               // First cycle only primes the RAM read of byte 0.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (byte_ready_i) begin
                  rp_q <= rp_q + 9'd1;
                  if (rp_q == 9'(SECTOR_BYTES - 1)) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign sd_lba_o      = lba_q;
   assign sd_rd_o       = {1'b0, rd_q};
   assign sd_wr_o       = 2'b00;
   assign sd_buff_din_o = 8'h00;
   assign byte_o        = valid_q ? ram_q : 8'h00;
   assign byte_valid_o  = valid_q;
   assign last_o        = valid_q && (rp_q == 9'(SECTOR_BYTES - 1));

endmodule
